// File: rtl/increment_count_rise_detect.sv
// Rising-edge qualifier for the count enable: registers en and flags the
// first cycle it is seen high. Same clock/reset pair as the counter.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise
);

    logic en_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    assign rise = en & ~en_q;

endmodule

// File: rtl/increment_count.sv
// Up-counter 0..MAX with clear, clamped load, wrap-or-saturate, optional
// rising-edge enable, terminal-count flag, wrap pulse and sticky overflow.
module increment_count #(
    parameter int WIDTH    = 3,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SATURATE = 0,
    parameter int EDGE_EN  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             inc;
    logic [WIDTH-1:0] load_clamped;

    generate
        if (EDGE_EN != 0) begin : g_edge
            rise_detect u_rise_detect (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .rise (inc)
            );
        end else begin : g_level
            assign inc = en;
        end
    endgenerate

    // Loads above MAX are clamped so the count never leaves 0..MAX.
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign tc           = (count == MAX_V);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_clamped;
            wrap  <= 1'b0;
        end else if (inc) begin
            if (count != MAX_V) begin
                count <= count + 1'b1;
                wrap  <= 1'b0;
            end else begin
                ovf <= 1'b1;
                if (SATURATE != 0) begin
                    wrap <= 1'b0;
                end else begin
                    count <= '0;
                    wrap  <= 1'b1;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_increment_count.sv
// Bench for increment_count: three configurations plus a two-stage cascade,
// checked every cycle against a behavioural model of the counting rules.
module tb_increment_count;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, cen = 1'b0;
    logic [2:0] lv = 3'd0;

    logic [2:0] cnt [3];
    logic       tcs [3];
    logic       wrs [3];
    logic       ovs [3];

    logic [2:0] cc0, cc1;
    logic       ctc0, ctc1, cw0, cw1, co0, co1;

    increment_count #(.WIDTH(3)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .count(cnt[0]), .tc(tcs[0]), .wrap(wrs[0]), .ovf(ovs[0]));

    increment_count #(.WIDTH(3), .MAX(5), .SATURATE(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .count(cnt[1]), .tc(tcs[1]), .wrap(wrs[1]), .ovf(ovs[1]));

    increment_count #(.WIDTH(3), .MAX(5), .EDGE_EN(1)) u_d2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(lv),
        .count(cnt[2]), .tc(tcs[2]), .wrap(wrs[2]), .ovf(ovs[2]));

    increment_count #(.WIDTH(3)) u_c0 (
        .clk(clk), .rst(rst), .en(cen), .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .count(cc0), .tc(ctc0), .wrap(cw0), .ovf(co0));

    increment_count #(.WIDTH(3)) u_c1 (
        .clk(clk), .rst(rst), .en(ctc0 & cen), .clr(1'b0), .load(1'b0), .load_val(3'd0),
        .count(cc1), .tc(ctc1), .wrap(cw1), .ovf(co1));

    // Model configuration and state
    int mx   [3] = '{7, 5, 5};
    int sat  [3] = '{0, 1, 0};
    int edg  [3] = '{0, 0, 1};
    int mc   [3];
    bit mw   [3];
    bit mo   [3];
    bit menq;
    int tot;
    bit cwrap_exp;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0; mw[i] = 0; mo[i] = 0;
        end
        menq = 0; tot = 0; cwrap_exp = 0;
    endfunction

    function automatic void model_step();
        for (int i = 0; i < 3; i++) begin
            bit inc;
            inc = (edg[i] != 0) ? (en && !menq) : en;
            if (clr) begin
                mc[i] = 0; mw[i] = 0; mo[i] = 0;
            end else if (load) begin
                mc[i] = (int'(lv) > mx[i]) ? mx[i] : int'(lv);
                mw[i] = 0;
            end else if (inc) begin
                if (mc[i] < mx[i]) begin
                    mc[i]++; mw[i] = 0;
                end else begin
                    mo[i] = 1;
                    if (sat[i] != 0) mw[i] = 0;
                    else begin mc[i] = 0; mw[i] = 1; end
                end
            end else begin
                mw[i] = 0;
            end
        end
        menq = en;
        if (cen) begin
            tot = (tot + 1) % 64;
            cwrap_exp = (tot == 0);
        end else begin
            cwrap_exp = 0;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count%0d", i), int'(cnt[i]), mc[i]);
            chk($sformatf("tc%0d", i),    int'(tcs[i]), int'(mc[i] == mx[i]));
            chk($sformatf("wrap%0d", i),  int'(wrs[i]), int'(mw[i]));
            chk($sformatf("ovf%0d", i),   int'(ovs[i]), int'(mo[i]));
        end
        chk("cascade_value", int'({cc1, cc0}), tot);
        chk("cascade_wrap",  int'(cw1), int'(cwrap_exp));
    endtask

    task automatic cycle(input bit e, input bit c, input bit l, input logic [2:0] v, input bit ce);
        en = e; clr = c; load = l; lv = v; cen = ce;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int pulses;
        model_reset();
        #12;
        check_all();
        rst = 1'b1;

        // Level wrap on d0, saturation on d1, then clear
        do_reset();
        for (int k = 0; k < 9; k++) cycle(1, 0, 0, 3'd0, 0);
        chk("sat_hold", int'(cnt[1]), 5);
        cycle(0, 1, 0, 3'd0, 0);
        chk("clr_ovf", int'(ovs[1]), 0);

        // Load clamp and priority
        cycle(0, 0, 1, 3'd7, 0);
        chk("load_clamp", int'(cnt[1]), 5);
        cycle(1, 1, 1, 3'd3, 1);
        cycle(1, 0, 1, 3'd2, 1);
        chk("load_over_inc", int'(cnt[0]), 2);

        // Edge mode pattern on d2
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 3'd0, 0);
        for (int k = 0; k < 2; k++) cycle(0, 0, 0, 3'd0, 0);
        cycle(1, 0, 0, 3'd0, 0);
        cycle(0, 0, 0, 3'd0, 0);
        chk("edge_two_incs", int'(cnt[2]), 2);

        // Async reset between edges at count 4, en held high across release
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1, 0, 0, 3'd0, 1);
        chk("pre_reset_cnt", int'(cnt[0]), 4);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        cycle(1, 0, 0, 3'd0, 0);
        chk("edge_after_release", int'(cnt[2]), 1);

        // Cascade: 64 enables, one upper-stage wrap
        do_reset();
        pulses = 0;
        for (int k = 0; k < 64; k++) begin
            cycle(0, 0, 0, 3'd0, 1);
            if (cw1) pulses++;
        end
        chk("cascade_pulses", pulses, 1);

        // Randomised traffic
        do_reset();
        for (int k = 0; k < 400; k++) begin
            cycle(bit'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
